// File: rtl/axi2apb_pkg.sv
// Shared types and helpers for the AXI-to-APB read/response mux.
package axi2apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Index width wide enough for every slave plus the decode-error slot.
    function automatic int slv_bits(input int num_slv);
        return $clog2(num_slv + 1);
    endfunction

    // The decode-error index sits one past the last real slave.
    function automatic int dec_err_idx(input int num_slv);
        return num_slv;
    endfunction

endpackage

// File: rtl/axi2apb_mux_nslv_if.sv
// Bridge-side and slave-side APB read/response signals of the N-slave mux.
// Handshake: psel opens a transfer and is held until the transfer is done; the
// completion cycle is psel & pready; prdata/pslverr are valid the cycle after.
interface axi2apb_mux_nslv_if #(
    parameter int NUM_SLV   = 8,
    parameter int ADDR_BITS = 24,
    parameter int DATA_W    = 32
);
    logic [ADDR_BITS-1:0]      cmd_addr;
    logic                      psel;
    logic [DATA_W-1:0]         prdata;
    logic                      pready;
    logic                      pslverr;
    logic [NUM_SLV-1:0]        psel_slv;
    logic [NUM_SLV-1:0]        pready_slv;
    logic [NUM_SLV-1:0]        pslverr_slv;
    logic [NUM_SLV*DATA_W-1:0] prdata_slv;
    logic                      err_dec;
    logic                      err_tout;

    modport master (
        output cmd_addr, psel, pready_slv, pslverr_slv, prdata_slv,
        input  prdata, pready, pslverr, psel_slv, err_dec, err_tout
    );

    modport slave (
        input  cmd_addr, psel, pready_slv, pslverr_slv, prdata_slv,
        output prdata, pready, pslverr, psel_slv, err_dec, err_tout
    );
endinterface

// File: rtl/axi2apb_mux_wdog.sv
// Saturating pready watchdog counter; expire is high while the count sits at LIMIT-1.
module axi2apb_mux_wdog #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(LIMIT) + 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = (cnt == LAST);
endmodule

// File: rtl/axi2apb_mux_nslv.sv
// APB read/response mux for NUM_SLV slaves with address-map decode and transfer FSM.
// Optional pready watchdog is built when APB_MUX_TOUT_EN is defined.
module axi2apb_mux_nslv
    import axi2apb_pkg::*;
#(
    parameter int                          NUM_SLV   = 8,
    parameter int                          ADDR_BITS = 24,
    parameter int                          DEC_BITS  = 4,
    parameter int                          DATA_W    = 32,
    parameter logic [NUM_SLV*DEC_BITS-1:0] SLV_BASE  = 'h76543210,
    parameter int                          TOUT_CYC  = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    axi2apb_mux_nslv_if.slave       bus,
    output state_t                  state_dbg
);
    localparam int IW = slv_bits(NUM_SLV);
    localparam logic [IW-1:0] DEC_ERR = IW'(dec_err_idx(NUM_SLV));

    state_t              state, state_nxt;
    logic [IW-1:0]       sel_q, dec_idx, idx_cur;
    logic                dec_err, slv_ready, slv_err, tout_fire, complete;
    logic [DATA_W-1:0]   slv_data, prdata_pre;
    logic                pslverr_pre;
    logic [DEC_BITS-1:0] addr_top;
    logic                unused_addr;

    assign addr_top    = bus.cmd_addr[ADDR_BITS-1 -: DEC_BITS];
    assign unused_addr = ^bus.cmd_addr[ADDR_BITS-DEC_BITS-1:0];

    // Scan downwards so the lowest matching slave index wins.
    always_comb begin
        dec_idx = DEC_ERR;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (SLV_BASE[i*DEC_BITS +: DEC_BITS] == addr_top) dec_idx = IW'(i);
        end
    end

    assign idx_cur = (state == IDLE) ? dec_idx : sel_q;
    assign dec_err = (idx_cur == DEC_ERR);

    always_comb begin
        slv_ready = 1'b0;
        slv_err   = 1'b0;
        slv_data  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_cur == IW'(i)) begin
                slv_ready = bus.pready_slv[i];
                slv_err   = bus.pslverr_slv[i];
                slv_data  = bus.prdata_slv[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef APB_MUX_TOUT_EN
    logic wd_expire;

    axi2apb_mux_wdog #(.LIMIT(TOUT_CYC)) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (state != BUSY || !bus.psel),
        .en     (state == BUSY && !slv_ready),
        .expire (wd_expire)
    );

    // A slave answering in the expiry cycle wins over the watchdog.
    assign tout_fire = (state == BUSY) && wd_expire && !slv_ready && !dec_err;
`else
    assign tout_fire = 1'b0;
`endif

    assign bus.pready  = (state == HOLD) || dec_err || slv_ready || tout_fire;
    assign pslverr_pre = dec_err || tout_fire || slv_err;
    assign prdata_pre  = (dec_err || tout_fire) ? '0 : slv_data;
    assign complete    = bus.psel && bus.pready && (state != HOLD);

    always_comb begin
        bus.psel_slv = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            bus.psel_slv[i] = reset && bus.psel && (state != HOLD) && (idx_cur == IW'(i));
        end
    end

    assign bus.err_dec  = reset && complete && dec_err;
    assign bus.err_tout = reset && complete && tout_fire;
    assign state_dbg    = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            sel_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.psel) sel_q <= dec_idx;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.psel) state_nxt = BUSY;
            BUSY:    if (bus.pready) state_nxt = HOLD;
            HOLD:    state_nxt = HOLD;
            default: state_nxt = IDLE;
        endcase
        if (!bus.psel) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset || !bus.psel) begin
            bus.prdata  <= '0;
            bus.pslverr <= 1'b0;
        end else if (complete) begin
            bus.prdata  <= prdata_pre;
            bus.pslverr <= pslverr_pre;
        end
    end
endmodule

// File: tb/tb_axi2apb_mux_nslv.sv
// Self-checking bench for axi2apb_mux_nslv: directed scenarios plus randomized traffic
// against a transaction-level model of the mux.
module tb_axi2apb_mux_nslv;
    import axi2apb_pkg::*;

    localparam int NUM_SLV   = 8;
    localparam int ADDR_BITS = 24;
    localparam int DEC_BITS  = 4;
    localparam int DATA_W    = 32;
    localparam int TOUT_CYC  = 16;
    localparam logic [31:0] SLV_BASE = 32'h1654_3210;
`ifdef APB_MUX_TOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    logic   clk   = 1'b0;
    logic   reset = 1'b0;
    state_t state_dbg;
    int     checks = 0;
    int     errors = 0;
    bit     mdl_on = 1'b0;

    axi2apb_mux_nslv_if #(.NUM_SLV(NUM_SLV), .ADDR_BITS(ADDR_BITS), .DATA_W(DATA_W)) bus ();

    axi2apb_mux_nslv #(
        .NUM_SLV   (NUM_SLV),
        .ADDR_BITS (ADDR_BITS),
        .DEC_BITS  (DEC_BITS),
        .DATA_W    (DATA_W),
        .SLV_BASE  (SLV_BASE),
        .TOUT_CYC  (TOUT_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Lowest slave whose map field equals the top address nibble; NUM_SLV if none.
    function automatic int decode(input logic [ADDR_BITS-1:0] a);
        logic [31:0] base;
        base = SLV_BASE;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (base[i*DEC_BITS +: DEC_BITS] == a[ADDR_BITS-1 -: DEC_BITS]) return i;
        end
        return NUM_SLV;
    endfunction

    // Transaction model: phase 0 = no open transfer, 1 = waiting on target, 2 = answered.
    int          m_phase = 0;
    int          m_idx   = 0;
    int          m_wait  = 0;
    logic [31:0] m_prdata  = '0;
    logic        m_pslverr = 1'b0;
    int          e_idx;
    bit          e_derr, e_srdy, e_fire, e_rdy, e_comp;
    logic [7:0]  e_sel;

    always @(negedge clk) begin
        if (mdl_on) begin
            e_idx  = (m_phase == 0) ? decode(bus.cmd_addr) : m_idx;
            e_derr = (e_idx == NUM_SLV);
            e_srdy = e_derr ? 1'b0 : bus.pready_slv[e_idx];
            e_fire = TOUT_EN && m_phase == 1 && !e_derr && !e_srdy && m_wait == TOUT_CYC - 1;
            e_rdy  = (m_phase == 2) || e_derr || e_srdy || e_fire;
            e_sel  = (reset && bus.psel && m_phase != 2 && !e_derr) ? 8'(1 << e_idx) : 8'h00;
            e_comp = bus.psel && e_rdy && m_phase != 2;

            check("pready",   bus.pready,   e_rdy);
            check("psel_slv", bus.psel_slv, e_sel);
            check("prdata",   bus.prdata,   m_prdata);
            check("pslverr",  bus.pslverr,  m_pslverr);
            check("err_dec",  bus.err_dec,  reset && e_comp && e_derr);
            check("err_tout", bus.err_tout, reset && e_comp && e_fire);

            if (!reset || !bus.psel) begin
                m_phase   = 0;
                m_wait    = 0;
                m_prdata  = '0;
                m_pslverr = 1'b0;
            end else begin
                if (e_comp) begin
                    m_prdata  = (e_derr || e_fire) ? 32'h0 : bus.prdata_slv[e_idx*DATA_W +: DATA_W];
                    m_pslverr = e_derr || e_fire || bus.pslverr_slv[e_idx];
                end
                if (m_phase == 0) begin
                    m_phase = 1;
                    m_idx   = e_idx;
                    m_wait  = 0;
                end else if (m_phase == 1) begin
                    if (e_comp) m_phase = 2;
                    else if (m_wait < TOUT_CYC - 1) m_wait++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_slave_data();
        for (int i = 0; i < NUM_SLV; i++) bus.prdata_slv[i*DATA_W +: DATA_W] = 32'hA5A5_0000 | 32'(i);
    endtask

    initial begin
        bus.psel        = 1'b1;
        bus.cmd_addr    = 24'h30_0000;
        bus.pready_slv  = '0;
        bus.pslverr_slv = '0;
        load_slave_data();

        // Reset: selects gated even with psel up, registers cleared.
        @(posedge clk);
        #1 mdl_on = 1'b1;
        @(negedge clk);
        check("rst_psel_slv", bus.psel_slv, 8'h00);
        check("rst_prdata",   bus.prdata,   32'h0);
        check("rst_pslverr",  bus.pslverr,  1'b0);
        check("rst_err_dec",  bus.err_dec,  1'b0);
        step();
        bus.psel = 1'b0;
        step();
        reset = 1'b1;

        // Slave 3 read, ready on the third transfer cycle.
        step();
        bus.psel = 1'b1;
        bus.cmd_addr = 24'h30_0000;
        @(negedge clk);
        check("s1_sel",  bus.psel_slv, 8'h08);
        check("s1_wait", bus.pready,   1'b0);
        step();
        step();
        bus.pready_slv = 8'h08;
        @(negedge clk);
        check("s1_rdy", bus.pready, 1'b1);
        step();
        bus.pready_slv = 8'h00;
        @(negedge clk);
        check("s1_data",    bus.prdata,   32'hA5A5_0003);
        check("s1_err",     bus.pslverr,  1'b0);
        check("s1_hold_sel", bus.psel_slv, 8'h00);
        step();
        bus.psel = 1'b0;

        // Decode error: unmapped nibble completes at once.
        step();
        bus.psel = 1'b1;
        bus.cmd_addr = 24'h80_0000;
        @(negedge clk);
        check("s2_sel",  bus.psel_slv, 8'h00);
        check("s2_rdy",  bus.pready,   1'b1);
        check("s2_edec", bus.err_dec,  1'b1);
        step();
        bus.psel = 1'b0;
        @(negedge clk);
        check("s2_err",  bus.pslverr, 1'b1);
        check("s2_data", bus.prdata,  32'h0);
        check("s2_edec_off", bus.err_dec, 1'b0);

        // Duplicate map value: slave 1 beats slave 7.
        step();
        bus.psel = 1'b1;
        bus.cmd_addr = 24'h1F_FFFF;
        @(negedge clk);
        check("lowest_wins", bus.psel_slv, 8'h02);
        step();
        bus.psel = 1'b0;

        // Address moves to slave 5 while waiting on slave 2.
        step();
        bus.psel = 1'b1;
        bus.cmd_addr = 24'h20_0000;
        step();
        bus.cmd_addr = 24'h50_0000;
        @(negedge clk);
        check("s5_sel", bus.psel_slv, 8'h04);
        step();
        bus.pready_slv = 8'h20;
        @(negedge clk);
        check("s5_other_rdy", bus.pready, 1'b0);
        step();
        bus.pready_slv = 8'h04;
        step();
        bus.pready_slv = 8'h00;
        @(negedge clk);
        check("s5_data", bus.prdata, 32'hA5A5_0002);
        step();
        bus.psel = 1'b0;

`ifdef APB_MUX_TOUT_EN
        // Slave 1 never ready: forced completion on the 16th wait cycle.
        step();
        bus.psel = 1'b1;
        bus.cmd_addr = 24'h10_0000;
        for (int k = 1; k <= TOUT_CYC - 1; k++) step();
        @(negedge clk);
        check("wd_15_rdy", bus.pready, 1'b0);
        step();
        @(negedge clk);
        check("wd_rdy",  bus.pready,   1'b1);
        check("wd_tout", bus.err_tout, 1'b1);
        step();
        @(negedge clk);
        check("wd_err",  bus.pslverr,  1'b1);
        check("wd_data", bus.prdata,   32'h0);
        check("wd_hold", bus.psel_slv, 8'h00);
        step();
        bus.psel = 1'b0;

        // Slave ready in the expiry cycle wins.
        step();
        bus.psel = 1'b1;
        for (int k = 1; k <= TOUT_CYC; k++) step();
        bus.pready_slv = 8'h02;
        @(negedge clk);
        check("col_tout", bus.err_tout, 1'b0);
        step();
        bus.pready_slv = 8'h00;
        @(negedge clk);
        check("col_err",  bus.pslverr, 1'b0);
        check("col_data", bus.prdata,  32'hA5A5_0001);
        step();
        bus.psel = 1'b0;
`endif

        // Reset while waiting on slave 4, then a fresh decode of slave 6.
        step();
        bus.psel = 1'b1;
        bus.cmd_addr = 24'h40_0000;
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        check("rst_mid_sel",  bus.psel_slv, 8'h00);
        check("rst_mid_data", bus.prdata,   32'h0);
        check("rst_mid_err",  bus.pslverr,  1'b0);
        bus.cmd_addr = 24'h60_0000;
        step();
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_sel", bus.psel_slv, 8'h40);
        step();
        bus.psel = 1'b0;

        // Randomized traffic: address churn, slow/fast slaves, aborts, rare resets.
        begin
            bit slow;
            slow = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                step();
                if (c % 100 == 0) slow = 1'($urandom_range(0, 1));
                reset = ($urandom_range(0, 399) != 0);
                if (!bus.psel) bus.psel = ($urandom_range(0, 2) != 0);
                else bus.psel = slow ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 2) == 0) bus.cmd_addr = 24'($urandom);
                for (int i = 0; i < NUM_SLV; i++) begin
                    bus.pready_slv[i] = slow ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
                    bus.prdata_slv[i*DATA_W +: DATA_W] = $urandom;
                end
                bus.pslverr_slv = 8'($urandom);
            end
        end

        step();
        reset = 1'b1;
        bus.psel = 1'b0;
        @(negedge clk);
        #1 mdl_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
